// File: rtl/pp_seq_mult_pkg.sv
// pp_mult_pkg: shared definitions for the sequential partial-product multiplier.
//   pp_state_t  - control FSM states (IDLE, RUN, DONE)
//   cnt_width   - width of the row-group counter, wide enough to hold W/P
//   trunc_mask  - 2W-bit mask that clears the low tc product columns
package pp_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } pp_state_t;

    function automatic int cnt_width(input int w, input int p);
        return $clog2(w / p) + 1;
    endfunction

    // Returned at 64 bits; callers cast down to their 2W row width.
    function automatic logic [63:0] trunc_mask(input int w, input int tc);
        logic [63:0] cols;
        logic [63:0] low;
        cols = (w >= 32) ? '1 : ((64'd1 << (2 * w)) - 64'd1);
        low  = (64'd1 << tc) - 64'd1;
        return cols & ~low;
    endfunction

endpackage

// File: rtl/pp_seq_mult_if.sv
// pp_seq_mult_if: operand and product streams of the sequential multiplier.
//   in_valid/in_ready  - operand handshake, carries x, y, trunc_en
//   out_valid/out_ready - product handshake, carries p (2W bits)
//   master - producer of operands / consumer of products
//   slave  - the multiplier itself
interface pp_seq_mult_if #(
    parameter int BITWIDTH = 8
);
    logic                         in_valid;
    logic                         in_ready;
    logic signed [BITWIDTH-1:0]   x;
    logic signed [BITWIDTH-1:0]   y;
    logic                         trunc_en;
    logic                         out_valid;
    logic                         out_ready;
    logic signed [2*BITWIDTH-1:0] p;

    modport master (
        output in_valid, x, y, trunc_en, out_ready,
        input  in_ready, out_valid, p
    );

    modport slave (
        input  in_valid, x, y, trunc_en, out_ready,
        output in_ready, out_valid, p
    );
endinterface

// File: rtl/pp_seq_mult_row_gen.sv
// pp_row_gen: one partial-product row, purely combinational.
//   x        - latched signed multiplicand (W bits)
//   y_bit    - multiplier bit selecting this row
//   row_idx  - row position i (shift amount)
//   last_row - row W-1, which carries negative weight
//   trunc_en - clear the low TRUNC_COLS columns of the row
//   row      - 2W-bit row, ready to be accumulated
module pp_row_gen
    import pp_mult_pkg::*;
#(
    parameter int BITWIDTH   = 8,
    parameter int TRUNC_COLS = 4,
    parameter int IW         = $clog2(BITWIDTH)
) (
    input  logic signed [BITWIDTH-1:0]   x,
    input  logic                         y_bit,
    input  logic [IW-1:0]                row_idx,
    input  logic                         last_row,
    input  logic                         trunc_en,
    output logic [2*BITWIDTH-1:0]        row
);

    localparam int PW = 2 * BITWIDTH;
    localparam logic [PW-1:0] MASK = PW'(trunc_mask(BITWIDTH, TRUNC_COLS));

    logic [PW-1:0] x_ext;
    logic [PW-1:0] x_sel;
    logic [PW-1:0] row_raw;

    // Negation happens after sign extension to 2W bits, so the most
    // negative multiplicand negates without overflow.
    always_comb begin
        x_ext   = {{BITWIDTH{x[BITWIDTH-1]}}, x};
        x_sel   = last_row ? (~x_ext + PW'(1)) : x_ext;
        row_raw = y_bit ? (x_sel << row_idx) : '0;
        row     = trunc_en ? (row_raw & MASK) : row_raw;
    end

endmodule

// File: rtl/pp_seq_mult.sv
// pp_seq_mult: sequential signed multiplier, PP_PER_CYCLE rows per cycle.
//   clk, rst_n - clock and asynchronous active-low reset
//   bus        - operand/product streams (slave modport)
//   busy       - high while a product is being formed or waiting to be taken
// Latency from acceptance to out_valid is BITWIDTH/PP_PER_CYCLE cycles.
module pp_seq_mult
    import pp_mult_pkg::*;
#(
    parameter int BITWIDTH     = 8,
    parameter int PP_PER_CYCLE = 1,
    parameter int TRUNC_COLS   = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    pp_seq_mult_if.slave bus,
    output logic         busy
);

    localparam int W  = BITWIDTH;
    localparam int P  = PP_PER_CYCLE;
    localparam int N  = W / P;
    localparam int CW = cnt_width(W, P);
    localparam int IW = $clog2(W);
    localparam int PW = 2 * W;

    if ((W < 2) || ((W % P) != 0) || (TRUNC_COLS < 0) || (TRUNC_COLS >= PW)) begin : g_param_check
        $error("pp_seq_mult: illegal BITWIDTH / PP_PER_CYCLE / TRUNC_COLS combination");
    end

    pp_state_t             state_q, state_d;
    logic signed [W-1:0]   x_q, x_d;
    logic [W-1:0]          y_q, y_d;
    logic                  trunc_q, trunc_d;
    logic [PW-1:0]         acc_q, acc_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  in_ready_q, in_ready_d;
    logic                  out_valid_q, out_valid_d;
    logic                  busy_q, busy_d;

    logic [PW-1:0]         rows [P];
    logic [IW-1:0]         row_idx [P];
    logic [PW-1:0]         row_sum;

    // Row group cnt covers rows cnt*P .. cnt*P+P-1.
    for (genvar j = 0; j < P; j++) begin : g_row
        assign row_idx[j] = IW'(int'(cnt_q) * P + j);

        pp_row_gen #(
            .BITWIDTH   (W),
            .TRUNC_COLS (TRUNC_COLS),
            .IW         (IW)
        ) u_row_gen (
            .x        (x_q),
            .y_bit    (y_q[row_idx[j]]),
            .row_idx  (row_idx[j]),
            .last_row (row_idx[j] == IW'(W - 1)),
            .trunc_en (trunc_q),
            .row      (rows[j])
        );
    end

    always_comb begin
        row_sum = '0;
        for (int j = 0; j < P; j++) begin
            row_sum = row_sum + rows[j];
        end
    end

    // Next-state logic; handshake outputs are registered alongside the state
    // so nothing on the ports depends combinationally on the inputs.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        trunc_d     = trunc_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    x_d        = bus.x;
                    y_d        = bus.y;
                    trunc_d    = bus.trunc_en;
                    acc_d      = '0;
                    cnt_d      = '0;
                    state_d    = RUN;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            RUN: begin
                acc_d = acc_q + row_sum;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            trunc_q     <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            trunc_q     <= trunc_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.p         = acc_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_pp_seq_mult.sv
// tb_pp_seq_mult: four W=8 multipliers (P = 1, 2, 4, 8, TRUNC_COLS = 4) driven
// from one shared operand stream, checked against an arithmetic model.
module tb_pp_seq_mult;

    localparam int NDUT = 4;
    localparam int TC   = 4;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               out_ready;
    logic signed [7:0]  x;
    logic signed [7:0]  y;
    logic               trunc_en;

    logic [NDUT-1:0]    rdy_v;
    logic [NDUT-1:0]    val_v;
    logic [NDUT-1:0]    busy_v;
    logic [15:0]        p_v [NDUT];

    int                 checks = 0;
    int                 errors = 0;
    int                 cyc = 0;
    int                 accept_cyc = 0;
    int                 valid_cyc [NDUT];
    logic [NDUT-1:0]    prev_val = '0;

    logic [NDUT-1:0]    m_busy;
    logic [NDUT-1:0]    m_done;
    int                 m_left [NDUT];
    logic [15:0]        m_exp [NDUT];

    logic signed [7:0]  dx [5] = '{8'sd13, -8'sd128, -8'sd128, -8'sd1, -8'sd1};
    logic signed [7:0]  dy [5] = '{8'sd11, -8'sd128, 8'sd127, -8'sd1, -8'sd1};
    logic               dt [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [15:0]        dp [5] = '{16'h008F, 16'h4000, 16'hC080, 16'h0001, 16'hFFD0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Devices under test, one per rows-per-cycle setting
    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        pp_seq_mult_if #(.BITWIDTH(8)) bus ();

        assign bus.in_valid  = in_valid;
        assign bus.x         = x;
        assign bus.y         = y;
        assign bus.trunc_en  = trunc_en;
        assign bus.out_ready = out_ready;

        pp_seq_mult #(
            .BITWIDTH     (8),
            .PP_PER_CYCLE (1 << g),
            .TRUNC_COLS   (TC)
        ) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus),
            .busy  (busy_v[g])
        );

        assign rdy_v[g] = bus.in_ready;
        assign val_v[g] = bus.out_valid;
        assign p_v[g]   = bus.p;
    end

    // Product as defined by the row rule: exact mode is the plain signed
    // product; approximate mode sums rows with their low TC columns cleared.
    function automatic logic [15:0] refProduct(input logic signed [7:0] a,
                                               input logic signed [7:0] b,
                                               input logic t);
        int acc;
        int row;
        if (!t) return 16'(int'(a) * int'(b));
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                row = (i == 7) ? -(int'(a) * 128) : int'(a) * (1 << i);
                acc = acc + (row & ~((1 << TC) - 1));
            end
        end
        return 16'(acc);
    endfunction

    task automatic check_val(input string name, input int g,
                             input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s (P=%0d): got 0x%0h, expected 0x%0h", name, 1 << g, act, exp);
        end
    endtask

    // Transaction-level model: a product accepted at an idle edge appears
    // 8/P edges later and stays until an edge with out_ready high.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int g = 0; g < NDUT; g++) begin
                m_busy[g] <= 1'b0;
                m_done[g] <= 1'b0;
                m_left[g] <= 0;
                m_exp[g]  <= '0;
            end
        end else begin
            for (int g = 0; g < NDUT; g++) begin
                if (!m_busy[g]) begin
                    if (in_valid) begin
                        m_busy[g] <= 1'b1;
                        m_left[g] <= 8 >> g;
                        m_exp[g]  <= refProduct(x, y, trunc_en);
                    end
                end else if (!m_done[g]) begin
                    m_left[g] <= m_left[g] - 1;
                    if (m_left[g] == 1) m_done[g] <= 1'b1;
                end else if (out_ready) begin
                    m_busy[g] <= 1'b0;
                    m_done[g] <= 1'b0;
                end
            end
        end
    end

    // Cycle-by-cycle comparison of every DUT against the model
    always @(negedge clk) begin
        for (int g = 0; g < NDUT; g++) begin
            check_val("in_ready", g, 32'(rdy_v[g]), 32'(!m_busy[g]));
            check_val("busy", g, 32'(busy_v[g]), 32'(m_busy[g]));
            check_val("out_valid", g, 32'(val_v[g]), 32'(m_done[g]));
            if (m_done[g]) check_val("p vs model", g, 32'(p_v[g]), 32'(m_exp[g]));
            if (val_v[g] && !prev_val[g]) valid_cyc[g] = cyc;
            prev_val[g] = val_v[g];
        end
    end

    task automatic applyStimulus(input logic signed [7:0] xv, input logic signed [7:0] yv,
                                 input logic tv);
        int guard;
        guard = 0;
        @(negedge clk);
        while (rdy_v != '1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (rdy_v != '1) check_val("idle wait timeout", 0, 32'(rdy_v), 32'hF);
        x        = xv;
        y        = yv;
        trunc_en = tv;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid   = 1'b0;
        accept_cyc = cyc;
    endtask

    // With out_ready low, waits until all DUTs hold a product, then checks
    // the literal value and the acceptance-to-valid latency of each.
    task automatic checkOutput(input logic [15:0] exp_p);
        int guard;
        guard = 0;
        while (val_v != '1 && guard < 30) begin
            @(negedge clk);
            guard++;
        end
        #1;
        if (val_v != '1) check_val("out_valid timeout", 0, 32'(val_v), 32'hF);
        for (int g = 0; g < NDUT; g++) begin
            check_val("p literal", g, 32'(p_v[g]), 32'(exp_p));
            check_val("latency", g, 32'(valid_cyc[g] - accept_cyc), 32'(8 >> g));
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        x         = '0;
        y         = '0;
        trunc_en  = 1'b0;
        repeat (3) @(negedge clk);
        for (int g = 0; g < NDUT; g++) begin
            check_val("reset in_ready", g, 32'(rdy_v[g]), 32'd1);
            check_val("reset out_valid", g, 32'(val_v[g]), 32'd0);
            check_val("reset busy", g, 32'(busy_v[g]), 32'd0);
            check_val("reset p", g, 32'(p_v[g]), 32'd0);
        end
        rst_n = 1'b1;

        // Hand-derived values pin the model; in truncated -1*-1 rows 0..4
        // each become 0xFFF0, giving -80-32-64+128 = -48.
        check_val("model 13*11", 0, 32'(refProduct(8'sd13, 8'sd11, 1'b0)), 32'h008F);
        check_val("model -128*127", 0, 32'(refProduct(-8'sd128, 8'sd127, 1'b0)), 32'hC080);
        check_val("model 3*-5", 0, 32'(refProduct(8'sd3, -8'sd5, 1'b0)), 32'hFFF1);
        check_val("model trunc -1*-1", 0, 32'(refProduct(-8'sd1, -8'sd1, 1'b1)), 32'hFFD0);

        for (int k = 0; k < 5; k++) begin
            out_ready = 1'b0;
            applyStimulus(dx[k], dy[k], dt[k]);
            checkOutput(dp[k]);
            if (k == 0) begin
                // Backpressure: product held, new operands ignored
                x        = 8'sd99;
                y        = 8'sd7;
                in_valid = 1'b1;
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    check_val("held p", 0, 32'(p_v[0]), 32'h008F);
                    check_val("held in_ready", 0, 32'(rdy_v[0]), 32'd0);
                end
                in_valid = 1'b0;
            end
            out_ready = 1'b1;
            @(negedge clk);
            #1;
            for (int g = 0; g < NDUT; g++) begin
                check_val("idle after consume", g, 32'(rdy_v[g]), 32'd1);
            end
        end

        // Reset in the third RUN cycle of the slowest DUT
        out_ready = 1'b1;
        applyStimulus(8'sd100, 8'sd77, 1'b0);
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        for (int g = 0; g < NDUT; g++) begin
            check_val("midrun reset out_valid", g, 32'(val_v[g]), 32'd0);
            check_val("midrun reset in_ready", g, 32'(rdy_v[g]), 32'd1);
            check_val("midrun reset p", g, 32'(p_v[g]), 32'd0);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b0;
        applyStimulus(8'sd3, -8'sd5, 1'b0);
        checkOutput(16'hFFF1);
        out_ready = 1'b1;

        // Random sweep, both modes, checked by the model on every cycle
        for (int k = 0; k < 1000; k++) begin
            applyStimulus(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                          1'($urandom_range(0, 1)));
        end
        repeat (12) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
